// File: rtl/sap3_pkg.sv
// Shared SAP3 definitions: reg file extension codes, select flag, stack pointer
// location, command opcodes and the stack sequencer state encoding.
package sap3_pkg;

    localparam logic [1:0] EXT_NONE = 2'b00;
    localparam logic [1:0] EXT_INC  = 2'b01;
    localparam logic [1:0] EXT_DEC  = 2'b10;
    localparam logic [1:0] EXT_INC2 = 2'b11;

    localparam logic       SEL_PAIR = 1'b1;

    localparam logic [3:0] SP_IDX   = 4'd10;
    localparam logic [3:0] MAX_PAIR = 4'd10;

    localparam logic       OP_PUSH  = 1'b0;
    localparam logic       OP_POP   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_P_LOAD,
        ST_P_DEC_H,
        ST_P_WR_H,
        ST_P_DEC_L,
        ST_P_WR_L,
        ST_Q_RD_L,
        ST_Q_INC_L,
        ST_Q_RD_H,
        ST_Q_INC_H,
        ST_Q_WB,
        ST_DONE
    } state_e;

    // Pairs are addressed by their high-byte register, so the index must be even.
    function automatic logic pair_illegal(input logic [3:0] pair, input logic [3:0] max_pair);
        return pair[0] || (pair > max_pair);
    endfunction

endpackage

// File: rtl/stack_seq.sv
// Stack sequencer: pushes/pops a 16-bit register pair through a byte-wide memory,
// using the register file's INC/DEC extension to move SP one byte at a time.
module stack_seq
    import sap3_pkg::*;
#(
    parameter logic [3:0] SP_IDX   = sap3_pkg::SP_IDX,
    parameter logic [3:0] MAX_PAIR = sap3_pkg::MAX_PAIR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [3:0]  cmd_pair,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [4:0]  rf_rd_sel,
    output logic [4:0]  rf_wr_sel,
    output logic [1:0]  rf_ext,
    output logic        rf_we,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    state_e      state_q, state_d;
    logic [3:0]  pair_q,  pair_d;
    logic        err_q,   err_d;
    logic [15:0] src_q,   src_d;
    logic [7:0]  lo_q,    lo_d;
    logic [7:0]  hi_q,    hi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pair_q  <= '0;
            err_q   <= 1'b0;
            src_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            err_q   <= err_d;
            src_q   <= src_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pair_d    = pair_q;
        err_d     = err_q;
        src_d     = src_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        busy      = (state_q != ST_IDLE);
        rf_rd_sel = '0;
        rf_wr_sel = '0;
        rf_ext    = EXT_NONE;
        rf_we     = 1'b0;
        rf_wdata  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid && !rst) begin
                    pair_d = cmd_pair;
                    err_d  = pair_illegal(cmd_pair, MAX_PAIR);
                    if (pair_illegal(cmd_pair, MAX_PAIR)) begin
                        state_d = ST_DONE;
                    end else if (cmd_op == OP_POP) begin
                        state_d = ST_Q_RD_L;
                    end else begin
                        state_d = ST_P_LOAD;
                    end
                end
            end

            // Source is captured before SP moves, so pushing SP stores its old value.
            ST_P_LOAD: begin
                rf_rd_sel = {SEL_PAIR, pair_q};
                src_d     = rf_rdata;
                state_d   = ST_P_DEC_H;
            end
            ST_P_DEC_H: begin
                rf_wr_sel = {SEL_PAIR, SP_IDX};
                rf_ext    = EXT_DEC;
                state_d   = ST_P_WR_H;
            end
            ST_P_WR_H: begin
                rf_rd_sel = {SEL_PAIR, SP_IDX};
                mem_addr  = rf_rdata;
                mem_wdata = src_q[15:8];
                mem_we    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_P_DEC_L;
                end
            end
            ST_P_DEC_L: begin
                rf_wr_sel = {SEL_PAIR, SP_IDX};
                rf_ext    = EXT_DEC;
                state_d   = ST_P_WR_L;
            end
            ST_P_WR_L: begin
                rf_rd_sel = {SEL_PAIR, SP_IDX};
                mem_addr  = rf_rdata;
                mem_wdata = src_q[7:0];
                mem_we    = 1'b1;
                if (mem_ready) begin
                    state_d = ST_DONE;
                end
            end

            ST_Q_RD_L: begin
                rf_rd_sel = {SEL_PAIR, SP_IDX};
                mem_addr  = rf_rdata;
                mem_re    = 1'b1;
                if (mem_ready) begin
                    lo_d    = mem_rdata;
                    state_d = ST_Q_INC_L;
                end
            end
            ST_Q_INC_L: begin
                rf_wr_sel = {SEL_PAIR, SP_IDX};
                rf_ext    = EXT_INC;
                state_d   = ST_Q_RD_H;
            end
            ST_Q_RD_H: begin
                rf_rd_sel = {SEL_PAIR, SP_IDX};
                mem_addr  = rf_rdata;
                mem_re    = 1'b1;
                if (mem_ready) begin
                    hi_d    = mem_rdata;
                    state_d = ST_Q_INC_H;
                end
            end
            ST_Q_INC_H: begin
                rf_wr_sel = {SEL_PAIR, SP_IDX};
                rf_ext    = EXT_INC;
                state_d   = ST_Q_WB;
            end
            // Write-back comes after both increments, so popping into SP wins over them.
            ST_Q_WB: begin
                rf_wr_sel = {SEL_PAIR, pair_q};
                rf_we     = 1'b1;
                rf_wdata  = {hi_q, lo_q};
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: register file and memory models around the DUT,
// with a pair/SP/memory-level reference model of PUSH and POP.
module tb_stack_seq;

    localparam int TIMEOUT = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [3:0]  cmd_pair;
    logic        done;
    logic        err;
    logic        busy;
    logic [4:0]  rf_rd_sel;
    logic [4:0]  rf_wr_sel;
    logic [1:0]  rf_ext;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    stack_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_pair  (cmd_pair),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .rf_rd_sel (rf_rd_sel),
        .rf_wr_sel (rf_wr_sel),
        .rf_ext    (rf_ext),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    bit [7:0] rf      [16];
    bit [7:0] mem     [65536];
    bit [7:0] exp_rf  [16];
    bit [7:0] exp_mem [65536];

    int checks   = 0;
    int failures = 0;

    int          ready_mode   = 0;
    int          stall_left   = 0;
    bit          stall_armed  = 1'b0;
    int          stall_glitch = 0;
    logic [15:0] snap_addr;
    logic [7:0]  snap_wdata;
    int          strobe_cnt   = 0;
    logic [15:0] rd_addrs [$];

    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx;
    logic [15:0] poke_val;

    // Register file: combinational read, clocked INC/DEC/write, plus a setup backdoor.
    always_comb begin
        logic [3:0] ri, rn;
        ri = rf_rd_sel[3:0];
        rn = ri + 4'd1;
        rf_rdata = rf_rd_sel[4] ? {rf[ri], rf[rn]} : {8'h00, rf[ri]};
    end

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        logic [3:0]  wi, wn;
        logic [15:0] pv;
        wi = rf_wr_sel[3:0];
        wn = wi + 4'd1;
        pv = {rf[wi], rf[wn]};
        case (rf_ext)
            2'b01:   pv = pv + 16'd1;
            2'b10:   pv = pv - 16'd1;
            2'b11:   pv = pv + 16'd2;
            default: ;
        endcase
        if (rf_ext != 2'b00) begin
            rf[wi] <= pv[15:8];
            rf[wn] <= pv[7:0];
        end
        if (rf_we) begin
            if (rf_wr_sel[4]) begin
                rf[wi] <= rf_wdata[15:8];
                rf[wn] <= rf_wdata[7:0];
            end else begin
                rf[wi] <= rf_wdata[7:0];
            end
        end
        if (poke_en) begin
            rf[poke_idx]        <= poke_val[15:8];
            rf[poke_idx + 4'd1] <= poke_val[7:0];
        end
        if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
        if (mem_re && mem_ready) rd_addrs.push_back(mem_addr);
        if (mem_we || mem_re) strobe_cnt++;
    end

    // Memory ready generator: 0 always ready, 1 random, 2 stall the first write, 3 never ready.
    always @(negedge clk) begin
        case (ready_mode)
            0: mem_ready = 1'b1;
            1: mem_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (mem_we && stall_left > 0) begin
                    if (stall_left == 3) begin
                        snap_addr  = mem_addr;
                        snap_wdata = mem_wdata;
                    end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata) begin
                        stall_glitch++;
                    end
                    stall_left--;
                    mem_ready = 1'b0;
                end else begin
                    if (mem_we && stall_armed) begin
                        if (mem_addr !== snap_addr || mem_wdata !== snap_wdata) stall_glitch++;
                        stall_armed = 1'b0;
                    end
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] getPair(input int i);
        return {exp_rf[i], exp_rf[i + 1]};
    endfunction

    task automatic putPair(input int i, input logic [15:0] v);
        exp_rf[i]     = v[15:8];
        exp_rf[i + 1] = v[7:0];
    endtask

    task automatic setPair(input logic [3:0] idx, input logic [15:0] v);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = idx;
        poke_val = v;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        putPair(int'(idx), v);
    endtask

    // Reference model: stack grows down, high byte at the higher address.
    task automatic modelCmd(input logic op, input logic [3:0] pair, output logic exp_err);
        logic [15:0] sp, v, a_hi, a_lo;
        exp_err = (pair % 2 == 1) || (pair > 10);
        if (exp_err) return;
        sp = getPair(10);
        if (op == 1'b0) begin
            v    = getPair(int'(pair));
            a_hi = sp - 16'd1;
            a_lo = sp - 16'd2;
            exp_mem[a_hi] = v[15:8];
            exp_mem[a_lo] = v[7:0];
            putPair(10, a_lo);
        end else begin
            a_lo = sp;
            a_hi = sp + 16'd1;
            v    = {exp_mem[a_hi], exp_mem[a_lo]};
            putPair(10, sp + 16'd2);
            putPair(int'(pair), v);
        end
    endtask

    task automatic applyStimulus(input logic op, input logic [3:0] pair, output int lat, output logic got_err);
        int waited = 0;
        @(negedge clk);
        while (!cmd_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pair  = pair;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_err = err;
    endtask

    task automatic checkState(input string tag);
        logic [127:0] got_rf, want_rf;
        int mism = 0;
        for (int i = 0; i < 16; i++) begin
            got_rf[i*8 +: 8]  = rf[i];
            want_rf[i*8 +: 8] = exp_rf[i];
        end
        for (int a = 0; a < 65536; a++) begin
            if (mem[a] != exp_mem[a]) mism++;
        end
        checkOutput({tag, "_regs"}, got_rf, want_rf);
        checkOutput({tag, "_mem_mismatches"}, mism, 0);
    endtask

    task automatic doCmd(input string tag, input logic op, input logic [3:0] pair, input int exp_lat);
        logic e_err, g_err;
        int   lat;
        modelCmd(op, pair, e_err);
        applyStimulus(op, pair, lat, g_err);
        checkOutput({tag, "_done_seen"}, done, 1'b1);
        checkOutput({tag, "_err"}, g_err, e_err);
        if (exp_lat > 0) checkOutput({tag, "_latency"}, lat, exp_lat);
        else checkOutput({tag, "_in_time"}, (lat < TIMEOUT), 1'b1);
        checkState(tag);
    endtask

    function automatic logic [57:0] outVec();
        return {done, err, busy, rf_rd_sel, rf_wr_sel, rf_ext, rf_we, rf_wdata,
                mem_addr, mem_wdata, mem_we, mem_re};
    endfunction

    initial begin
        int          strobes_before;
        logic [3:0]  rp;
        logic        rop;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_pair  = 4'd0;
        mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", outVec(), 58'd0);
        checkOutput("reset_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_cmd_ready", cmd_ready, 1'b1);
        checkOutput("idle_outputs", outVec(), 58'd0);

        for (int i = 0; i < 5; i++) setPair(4'(2 * i), 16'($urandom));
        setPair(4'd10, 16'h2000);
        setPair(4'd0, 16'h1234);

        doCmd("push_bc", 1'b0, 4'd0, 6);
        checkOutput("push_bc_hi_byte", mem[16'h1FFF], 8'h12);
        checkOutput("push_bc_lo_byte", mem[16'h1FFE], 8'h34);
        checkOutput("push_bc_sp", {rf[10], rf[11]}, 16'h1FFE);

        rd_addrs.delete();
        doCmd("pop_de", 1'b1, 4'd2, 6);
        checkOutput("pop_de_value", {rf[2], rf[3]}, 16'h1234);
        checkOutput("pop_de_sp", {rf[10], rf[11]}, 16'h2000);
        checkOutput("pop_de_nreads", rd_addrs.size(), 2);
        if (rd_addrs.size() == 2) begin
            checkOutput("pop_de_read0", rd_addrs[0], 16'h1FFE);
            checkOutput("pop_de_read1", rd_addrs[1], 16'h1FFF);
        end

        setPair(4'd10, 16'h0001);
        setPair(4'd4, 16'hABCD);
        doCmd("push_wrap", 1'b0, 4'd4, 6);
        checkOutput("push_wrap_hi", mem[16'h0000], 8'hAB);
        checkOutput("push_wrap_lo", mem[16'hFFFF], 8'hCD);
        checkOutput("push_wrap_sp", {rf[10], rf[11]}, 16'hFFFF);

        setPair(4'd10, 16'h1000);
        setPair(4'd6, 16'hC3A5);
        stall_left   = 3;
        stall_armed  = 1'b1;
        stall_glitch = 0;
        ready_mode   = 2;
        doCmd("push_stall", 1'b0, 4'd6, 9);
        checkOutput("stall_consumed", stall_left, 0);
        checkOutput("stall_outputs_stable", stall_glitch, 0);
        ready_mode = 0;

        strobes_before = strobe_cnt;
        doCmd("illegal_odd", 1'b0, 4'd3, 1);
        doCmd("illegal_high", 1'b1, 4'd12, 1);
        checkOutput("illegal_no_strobes", strobe_cnt - strobes_before, 0);

        setPair(4'd6, 16'h5A6B);
        setPair(4'd10, 16'h4000);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_pair  = 4'd6;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ready_mode = 3;
        checkOutput("in_wr_l", {mem_we, mem_wdata, mem_addr}, {1'b1, 8'h6B, 16'h3FFE});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midcmd_reset_outputs", outVec(), 58'd0);
        checkOutput("midcmd_reset_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        ready_mode = 0;
        #1;
        checkOutput("after_reset_ready", cmd_ready, 1'b1);
        exp_mem[16'h3FFF] = 8'h5A;
        putPair(10, 16'h3FFE);
        checkState("midcmd_reset");

        setPair(4'd10, 16'h3000);
        doCmd("push_sp", 1'b0, 4'd10, 6);
        checkOutput("push_sp_hi", mem[16'h2FFF], 8'h30);
        checkOutput("push_sp_lo", mem[16'h2FFE], 8'h00);

        ready_mode = 1;
        for (int n = 0; n < 24; n++) begin
            rop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) rp = 4'($urandom_range(0, 15));
            else rp = 4'(2 * $urandom_range(0, 5));
            doCmd("random", rop, rp, ((rp % 2 == 1) || (rp > 10)) ? 1 : 0);
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
